// File: rtl/karatsuba_pkg.sv
// Shared constants and elaboration helpers for the Karatsuba multiplier.
package karatsuba_pkg;

  // Default operand width at or below which the schoolbook product is used.
  localparam int unsigned BaseWDefault = 4;

  // Below this width the middle term (w-h+1) does not shrink, so recursion must stop.
  localparam int unsigned MinSplitW = 4;

  // Deepest recursion allowed before elaboration is flagged as suspicious.
  localparam int unsigned MaxDepth = 16;

  // Low-half width for a w-bit split.
  function automatic int unsigned split_point(int unsigned w);
    return w / 2;
  endfunction

  // True when a w-bit product should be built directly.
  function automatic bit is_base(int unsigned w, int unsigned base_w);
    return (w <= base_w) || (w < MinSplitW);
  endfunction

  // Depth of the deepest branch; the middle (sum) branch is always the widest.
  function automatic int unsigned rec_depth(int unsigned w, int unsigned base_w);
    int unsigned d;
    int unsigned cur;
    d   = 0;
    cur = w;
    while (!is_base(cur, base_w)) begin
      cur = cur - split_point(cur) + 1;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/karatsuba_core.sv
// Purely combinational recursive Karatsuba multiplier, W x W -> 2W unsigned.
module karatsuba_core
  import karatsuba_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter int unsigned BASE_W = BaseWDefault
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (is_base(W, BASE_W)) begin : g_base
    logic [2*W-1:0] a_ext, b_ext;
    assign a_ext = (2*W)'(a_i);
    assign b_ext = (2*W)'(b_i);
    assign p_o   = a_ext * b_ext;
  end else begin : g_rec
    localparam int unsigned H = split_point(W);
    localparam int unsigned L = W - H;
    localparam int unsigned M = L + 1;

    logic [H-1:0]   a0, b0;
    logic [L-1:0]   a1, b1;
    logic [M-1:0]   sa, sb;
    logic [2*H-1:0] z0;
    logic [2*L-1:0] z2;
    logic [2*M-1:0] zm, z1;

    assign a0 = a_i[H-1:0];
    assign a1 = a_i[W-1:H];
    assign b0 = b_i[H-1:0];
    assign b1 = b_i[W-1:H];
    assign sa = M'(a0) + M'(a1);
    assign sb = M'(b0) + M'(b1);

    karatsuba_core #(.W(H), .BASE_W(BASE_W)) u_lo (.a_i(a0), .b_i(b0), .p_o(z0));
    karatsuba_core #(.W(L), .BASE_W(BASE_W)) u_hi (.a_i(a1), .b_i(b1), .p_o(z2));
    karatsuba_core #(.W(M), .BASE_W(BASE_W)) u_mid (.a_i(sa), .b_i(sb), .p_o(zm));

    // zm >= z0 + z2 always, so the subtraction never wraps.
    assign z1  = zm - (2*M)'(z0) - (2*M)'(z2);
    assign p_o = ((2*W)'(z2) << (2*H)) + ((2*W)'(z1) << H) + (2*W)'(z0);
  end

endmodule

// File: rtl/karatsuba_mul.sv
// Registered Karatsuba multiplier wrapper: 1-cycle latency, one op per cycle.
// Define KARATSUBA_IN_REG_EN to add an input register stage (2-cycle latency).
module karatsuba_mul
  import karatsuba_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned BASE_W = BaseWDefault
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N-1:0]   input_0,
  input  logic [N-1:0]   input_1,
  output logic           out_valid,
  output logic [2*N-1:0] output_2
);

  localparam int unsigned Depth = rec_depth(N, BASE_W);

  logic [N-1:0]   core_a, core_b;
  logic           core_v;
  logic [2*N-1:0] core_p;
  logic [2*N-1:0] prod_q;
  logic           valid_q;

  // Elaboration sanity check on the configuration.
  always_comb begin
    assert (N >= 1 && Depth <= MaxDepth)
      else $error("karatsuba_mul: bad configuration N=%0d depth=%0d", N, Depth);
  end

`ifdef KARATSUBA_IN_REG_EN
  logic [N-1:0] a_q, b_q;
  logic         v_q;

  // Input stage; operands load only on valid so idle inputs never reach the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        a_q <= input_0;
        b_q <= input_1;
      end
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_v = v_q;
`else
  assign core_a = input_0;
  assign core_b = input_1;
  assign core_v = in_valid;
`endif

  karatsuba_core #(
    .W      (N),
    .BASE_W (BASE_W)
  ) u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // Output stage; product holds when no valid operation arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= core_v;
      if (core_v) begin
        prod_q <= core_p;
      end
    end
  end

  assign output_2  = prod_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_karatsuba_mul.sv
// Scoreboard bench for karatsuba_mul over several operand widths.
module tb_karatsuba_mul;

`ifdef KARATSUBA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NW = 7;

  function automatic int unsigned wsel(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 6;
      3:       return 7;
      4:       return 10;
      5:       return 17;
      default: return 33;
    endcase
  endfunction

  logic clk;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nmis  = 0;
  int   ndone = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NW; g++) begin : g_w
    localparam int unsigned W = wsel(g);

    logic           rst, iv, ov;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    logic           rst_edge = 1'b1;
    logic [2*W-1:0] held     = '0;
    logic [2*W+31:0] exp_q[$];  // {due cycle, product}
    logic [2*W+1:0]  st[$];     // {rst, in_valid, a, b}

    karatsuba_mul #(
      .N      (W),
      .BASE_W (4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .input_0   (a),
      .input_1   (b),
      .out_valid (ov),
      .output_2  (p)
    );

    always @(posedge clk) rst_edge <= rst;

    // Monitor: every cycle the output must be zero (reset), the due product, or held.
    always @(negedge clk) begin
      if (cyc > 0) begin
        nvec++;
        if (rst_edge) begin
          if (ov !== 1'b0 || p !== '0) begin
            nmis++;
            $display("FAIL w%0d reset: output_2=%0h out_valid=%0b, required 0 / 0", W, p, ov);
          end
          held = '0;
        end else if (exp_q.size() > 0 && exp_q[0][2*W+31:2*W] == 32'(cyc)) begin
          if (ov !== 1'b1 || p !== exp_q[0][2*W-1:0]) begin
            nmis++;
            $display("FAIL w%0d product cyc%0d: output_2=%0h out_valid=%0b, required %0h / 1",
                     W, cyc, p, ov, exp_q[0][2*W-1:0]);
          end
          held = exp_q[0][2*W-1:0];
          void'(exp_q.pop_front());
        end else begin
          if (ov !== 1'b0 || p !== held) begin
            nmis++;
            $display("FAIL w%0d hold cyc%0d: output_2=%0h out_valid=%0b, required %0h / 0",
                     W, cyc, p, ov, held);
          end
        end
      end
    end

    // Stimulus: build the vector list, then drive it one per cycle.
    initial begin
      logic [W-1:0]    ones, msb, x, y;
      logic [63:0]     r;
      logic [2*W+1:0]  it;
      logic [2*W-1:0]  e;
      ones = '1;
      msb  = '0;
      msb[W-1] = 1'b1;

      st.push_back({1'b1, 1'b1, W'(5), W'(7)});
      st.push_back({1'b1, 1'b1, W'(5), W'(7)});
      st.push_back({1'b0, 1'b1, W'(5), W'(7)});
      st.push_back({1'b0, 1'b1, W'(0), ones});
      st.push_back({1'b0, 1'b1, ones, ones});
      st.push_back({1'b0, 1'b1, msb, W'(2)});
      st.push_back({1'b0, 1'b1, W'(1), ones});
      st.push_back({1'b0, 1'b1, W'(3), W'(4)});
      st.push_back({1'b0, 1'b0, W'(0), W'(0)});
      if (W == 6) begin
        for (int i = 0; i < 64; i++)
          for (int j = 0; j < 64; j++) st.push_back({1'b0, 1'b1, W'(i), W'(j)});
      end else begin
        for (int i = 0; i < 200; i++) begin
          r = {$urandom(), $urandom()};
          x = r[W-1:0];
          r = {$urandom(), $urandom()};
          y = r[W-1:0];
          if (i % 25 == 0) x = ones;
          st.push_back({1'b0, ($urandom_range(0, 3) != 0), x, y});
        end
      end
      // Reset in the middle of a valid stream.
      for (int i = 0; i < 3; i++) st.push_back({1'b0, 1'b1, ones, W'(i + 1)});
      st.push_back({1'b1, 1'b1, ones, ones});
      st.push_back({1'b1, 1'b1, ones, ones});
      for (int i = 0; i < 3; i++) st.push_back({1'b0, 1'b1, W'(i + 2), ones});
      for (int i = 0; i < LAT + 3; i++) st.push_back({1'b0, 1'b0, W'($urandom), W'($urandom)});

      for (int i = 0; i < st.size(); i++) begin
        it  = st[i];
        rst = it[2*W+1];
        iv  = it[2*W];
        a   = it[2*W-1:W];
        b   = it[W-1:0];
        if (rst) begin
          while (exp_q.size() > 0 && exp_q[exp_q.size()-1][2*W+31:2*W] > 32'(cyc))
            void'(exp_q.pop_back());
        end else if (iv) begin
          e = (2*W)'(a) * (2*W)'(b);
          exp_q.push_back({32'(cyc + LAT), e});
        end
        @(posedge clk);
        #1;
      end

      nvec++;
      if (exp_q.size() != 0) begin
        nmis++;
        $display("FAIL w%0d drain: %0d results outstanding, required 0", W, exp_q.size());
      end
      ndone++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && ndone < NW; i++) @(posedge clk);
    nvec++;
    if (ndone != NW) begin
      nmis++;
      $display("FAIL timeout: %0d streams finished, required %0d", ndone, NW);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/karatsuba_mul.md
Name: karatsuba_mul

Overview:
- Unsigned N×N → 2N-bit integer multiplier built from a recursive Karatsuba decomposition.
- Combinational Karatsuba core followed by a registered output stage.
- Single clock domain; a drop-in arithmetic leaf for generated datapaths.
- Result must be bit-exact with the native unsigned product a*b.

Parameters:
- N, 10, operand width in bits (≥1).
- BASE_W, 4, operand width at or below which recursion stops and a direct (schoolbook) multiplier is used (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies input_0/input_1 this cycle.
- input_0  input  N  unsigned multiplicand.
- input_1  input  N  unsigned multiplier.
- out_valid  output  1  output_2 holds a valid product.
- output_2  output  2N  unsigned product input_0*input_1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, output_2←0 and out_valid←0. Reset takes priority over in_valid.
- Latency: exactly 1 cycle. The product of operands sampled at edge k appears on output_2 after edge k, with out_valid=1.
- Throughput: one operation per cycle, with no backpressure and no stall.
- out_valid is a registered copy of in_valid.
- output_2 updates only when in_valid=1. Otherwise it holds its previous value.
- Reset mid-stream: any in-flight result is discarded. The first valid result after rst deasserts is the product of the first operands sampled with rst=0 and in_valid=1.
- Core recursion for width w > BASE_W:
  - h = floor(w/2); a = a1·2^h + a0, b = b1·2^h + b0, with a0,b0 = h bits and a1,b1 = w−h bits.
  - z0 = a0·b0 (2h bits); z2 = a1·b1 (2(w−h) bits).
  - Sums sa = a0+a1 and sb = b0+b1 are (w−h+1) bits. zm = sa·sb is computed recursively at width w−h+1.
  - z1 = zm − z0 − z2. This is always non-negative; carry it at 2(w−h+1) bits.
  - result = (z2<<2h) + (z1<<h) + z0, truncated to 2w bits (exact; no overflow is lost).
- Base case (w ≤ BASE_W): direct unsigned product, 2w bits.
- Odd widths and N < BASE_W must be handled (N=1 reduces to an AND gate).
- Boundary values:
  - 0·x = 0.
  - (2^N−1)² = 2^2N − 2^(N+1) + 1 (for N=10: 1046529).
- X/Z on inputs while in_valid=0 must not propagate into output_2.

Optional Feature:
- Macro KARATSUBA_IN_REG_EN.
- When defined: input_0, input_1 and in_valid are registered before the core. Latency becomes 2 cycles, throughput stays 1/cycle, and rst also clears the input registers to 0.
- When undefined: 1-cycle latency as above.

Decomposition:
- Shared package karatsuba_pkg holds:
  - the default BASE_W constant;
  - a function computing the split point h(w);
  - a function computing the recursion depth, for lint/assertions.
- A natural sub-module is karatsuba_core: purely combinational and parameterized by width W. It instantiates itself recursively via generate: three children at widths h, w−h, w−h+1, and a schoolbook product at the base case.
- karatsuba_mul wraps karatsuba_core with the valid/output registers (plus optional input registers).

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, input_0=5, input_1=7 → output_2=0, out_valid=0 throughout. After release, next result is 35 one cycle later.
- Corners (N=10):
  - 0×1023 → 0.
  - 1023×1023 → 1046529.
  - 512×2 → 1024.
  - 1×1023 → 1023.
- Exhaustive: re-parameterize N=6 and sweep all 4096 pairs, one per cycle back-to-back → every output_2 equals the reference product one cycle later, out_valid=1.
- Random: 200 random 10-bit pairs with in_valid toggled randomly → products match when out_valid=1, and output_2 holds when in_valid=0.
- Widths: N∈{1,3,7,17,33} with random vectors, including all-ones → exact match (odd splits, base-case edge).
- With KARATSUBA_IN_REG_EN: 3×4 issued at edge k → output_2=12 after edge k+2. Reset mid-pipeline clears both stages.
